// File: rtl/mem_seq.sv
// Load/store sequencer: splits core loads/stores into byte accesses
// on the data-memory port and returns extended load data.
module mem_seq #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_func3,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t            state;
  logic              we;
  logic [2:0]        f3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [1:0]        k;
  logic              err;
  logic [31:0]       data;

  logic              bad_f3;
  logic              bad_align;
  logic              bad_range;
  logic              req_err;
  logic [1:0]        last;
  logic              access;
  logic [31:0]       ext;
  logic              unused_rdata;

  assign unused_rdata = ^mem_rdata[31:8];

  // Index of the final byte: 0, 1 or 3 for byte, half, word.
  assign last = {f3[1], f3[1] | f3[0]};

  always_comb begin
    bad_f3 = (req_func3[1:0] == 2'b11)
           || (req_func3[2] && (req_we || req_func3[1]));
    bad_align = (req_func3[1:0] == 2'b01 && req_addr[0])
              || (req_func3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    bad_range = |req_addr[31:ADDR_W];
    req_err = bad_f3 || bad_align || bad_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      we    <= 1'b0;
      f3    <= 3'b000;
      addr  <= '0;
      wdata <= '0;
      k     <= 2'd0;
      err   <= 1'b0;
      data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we    <= req_we;
            f3    <= req_func3;
            addr  <= req_addr[ADDR_W-1:0];
            wdata <= req_wdata;
            k     <= 2'd0;
            data  <= '0;
            err   <= req_err;
            state <= req_err ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (!we) data[{k, 3'b000} +: 8] <= mem_rdata[7:0];
          k <= k + 2'd1;
          if (k == last) state <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port decoded purely from registered state.
  assign access    = (state == ACCESS);
  assign MemRead   = access && !we;
  assign MemWrite  = access && we;
  assign mem_addr  = access ? addr + ADDR_W'(k) : '0;
  assign mem_func3 = MemRead ? 3'b100 : 3'b000;
  assign mem_wdata = MemWrite ? {24'h0, wdata[{k, 3'b000} +: 8]} : '0;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && err;

  always_comb begin
    ext = '0;
    unique case (f3)
      3'b000:  ext = {{24{data[7]}}, data[7:0]};
      3'b001:  ext = {{16{data[15]}}, data[15:0]};
      3'b100:  ext = {24'h0, data[7:0]};
      3'b101:  ext = {16'h0, data[15:0]};
      default: ext = data;
    endcase
  end

  assign resp_rdata = (resp_valid && !err && !we) ? ext : '0;

endmodule

// File: tb/tb_mem_seq.sv
// Scoreboard bench for mem_seq: model-derived responses and
// memory-port accesses are queued and checked by a monitor.
module tb_mem_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [11:0] mem_addr;
  logic [2:0]  mem_func3;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_seq #(.ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_addr(mem_addr), .mem_func3(mem_func3),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [4096];
  logic [7:0] ref_mem [4096];

  always @(posedge clk)
    if (MemWrite) mem[mem_addr] <= mem_wdata[7:0];
  assign mem_rdata = {24'h0, mem[mem_addr]};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    int         a;
    logic       w;
    logic [7:0] d;
  } acc_t;

  exp_t rq[$];
  acc_t aq[$];

  int compared = 0;
  int mismatched = 0;
  bit hold = 1'b0;
  bit rnd = 1'b0;

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic void fail(string nm);
    compared++;
    mismatched++;
    $display("FAIL %s at %0t", nm, $time);
  endfunction

  function automatic int size_of(logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  // Reference model: what the core should see and what the port should do.
  function automatic void model(logic w, logic [2:0] f,
                                logic [31:0] a, logic [31:0] d);
    int sz;
    bit legal;
    logic [31:0] v;
    exp_t e;
    acc_t x;
    sz = size_of(f);
    legal = w ? (f inside {3'd0, 3'd1, 3'd2})
              : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal || (a % sz) != 0 || a >= 4096) begin
      e.rdata = 0; e.err = 1'b1; e.lat = 1;
      rq.push_back(e);
      return;
    end
    v = 0;
    for (int i = 0; i < sz; i++) begin
      x.a = int'(a) + i;
      x.w = w;
      x.d = w ? d[8*i +: 8] : 8'h00;
      aq.push_back(x);
      if (w) ref_mem[x.a] = x.d;
      else v = v | (32'(ref_mem[x.a]) << (8 * i));
    end
    if (!w && !f[2] && sz < 4 && v[8*sz-1])
      v = v - (32'd1 << (8 * sz));
    e.rdata = w ? 32'h0 : v;
    e.err = 1'b0;
    e.lat = sz + 1;
    rq.push_back(e);
  endfunction

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail("req_ready_timeout");
  endtask

  task automatic issue(input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    wait_ready();
    model(w, f, a, d);
    req_we = w; req_func3 = f; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && rq.size() != 0; i++) @(posedge clk);
    #1;
    check("resp_queue_empty", 32'(rq.size()), 0);
    check("access_queue_empty", 32'(aq.size()), 0);
  endtask

  task automatic set_word(int a, logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      mem[a+i] = v[8*i +: 8];
      ref_mem[a+i] = v[8*i +: 8];
    end
  endtask

  always begin
    @(posedge clk); #1;
    resp_ready = hold ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  int  n = 0;
  int  start = 0;
  bit  seen = 1'b0;
  bit  hs = 1'b0;

  always @(negedge clk) begin
    n++;
    if (!rst_n) begin
      seen = 1'b0;
      hs = 1'b0;
    end else begin
      if (hs) begin
        check("valid_drops_after_hs", 32'(resp_valid), 0);
        check("ready_after_hs", 32'(req_ready), 1);
        hs = 1'b0;
      end
      if (req_valid && req_ready) start = n;
      if (resp_valid) begin
        check("no_req_ready_in_resp", 32'(req_ready), 0);
        if (rq.size() == 0) fail("resp_unexpected");
        else begin
          if (!seen) begin
            check("latency", 32'(n - start), 32'(rq[0].lat));
            seen = 1'b1;
          end
          check("resp_rdata", resp_rdata, rq[0].rdata);
          check("resp_err", 32'(resp_err), 32'(rq[0].err));
          if (resp_ready) begin
            void'(rq.pop_front());
            seen = 1'b0;
            hs = 1'b1;
          end
        end
      end
      if (MemRead || MemWrite) begin
        check("strobe_excl", 32'(MemRead & MemWrite), 0);
        if (aq.size() == 0) fail("access_unexpected");
        else begin
          acc_t x;
          x = aq.pop_front();
          check("mem_addr", 32'(mem_addr), 32'(x.a));
          check("mem_write", 32'(MemWrite), 32'(x.w));
          check("mem_func3", 32'(mem_func3), x.w ? 0 : 4);
          check("mem_wdata", mem_wdata, x.w ? {24'h0, x.d} : 0);
        end
      end else begin
        check("idle_func3", 32'(mem_func3), 0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic        w;
    int          r;
    int          sz;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b000;
    req_addr = 0; req_wdata = 0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", 32'(resp_err), 0);
    check("rst_memread", 32'(MemRead), 0);
    check("rst_memwrite", 32'(MemWrite), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_func3", 32'(mem_func3), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;

    set_word(0, 17);
    set_word(4, 9);
    set_word(8, 25);
    issue(0, 3'b010, 8, 0);
    issue(1, 3'b000, 5, 32'h1A5);
    issue(0, 3'b100, 5, 0);
    issue(0, 3'b000, 5, 0);
    issue(1, 3'b001, 6, 32'h8001);
    issue(0, 3'b001, 6, 0);
    issue(0, 3'b101, 6, 0);
    issue(0, 3'b010, 4, 0);
    issue(0, 3'b010, 2, 0);
    issue(0, 3'b010, 4096, 0);
    issue(0, 3'b011, 0, 0);

    issue(0, 3'b010, 0, 0);
    hold = 1'b1;
    for (int i = 0; i < 50 && !resp_valid; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    hold = 1'b0;
    drain();

    rnd = 1'b1;
    for (int it = 0; it < 150; it++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f = 3'($urandom_range(0, 7));
      else if (w) f = 3'($urandom_range(0, 2));
      else begin
        r = $urandom_range(0, 4);
        f = (r > 2) ? 3'(r + 1) : 3'(r);
      end
      sz = size_of(f);
      a = 32'($urandom_range(0, 4095));
      r = $urandom_range(0, 19);
      if (r >= 2 && sz != 0) a = a & ~32'(sz - 1);
      if (r == 0) a = a + 32'($urandom_range(1, 255) << 12);
      issue(w, f, a, $urandom);
    end
    drain();
    rnd = 1'b0;

    wait_ready();
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    begin
      acc_t x;
      x.w = 1'b1;
      x.a = 12; x.d = 8'hEF; aq.push_back(x);
      x.a = 13; x.d = 8'hBE; aq.push_back(x);
      ref_mem[12] = 8'hEF;
      ref_mem[13] = 8'hBE;
    end
    req_we = 1'b1; req_func3 = 3'b010; req_addr = 12;
    req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_memwrite", 32'(MemWrite), 0);
    check("rst_mid_memread", 32'(MemRead), 0);
    check("rst_mid_idle", 32'(req_ready), 1);
    check("rst_mid_no_resp", 32'(resp_valid), 0);
    check("partial_byte14", 32'(mem[14]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("partial_access_queue", 32'(aq.size()), 0);
    issue(0, 3'b010, 12, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
